// File: rtl/smc_timing_fsm.sv
// Static-memory-controller timing engine: sequences one external access through
// STORE, leading-edge, read/write, float and bus-turnaround phases.
module smc_timing_fsm #(
  parameter int unsigned NUM_CS = 4,
  parameter int unsigned WS_W   = 8,
  parameter int unsigned CSLE_W = 2,
  parameter int unsigned CSTE_W = 2,
  parameter int unsigned TURN_W = 2
) (
  input  logic              sys_clk,
  input  logic              sys_reset,
  input  logic              acc_valid,
  output logic              acc_ready,
  input  logic              acc_read,
  input  logic [NUM_CS-1:0] acc_cs,
  input  logic              acc_last,
  input  logic [CSLE_W-1:0] t_csle,
  input  logic [WS_W-1:0]   t_ws,
  input  logic [CSTE_W-1:0] t_cste,
  input  logic [WS_W-1:0]   t_oete,
  input  logic [TURN_W-1:0] t_turn,
  output logic [NUM_CS-1:0] cs_n,
  output logic              oe_n,
  output logic              we_n,
  output logic              latch_data,
  output logic              smc_done,
  output logic              smc_idle,
  output logic [2:0]        smc_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_STORE = 3'd1,
    S_LE    = 3'd2,
    S_RW    = 3'd3,
    S_FLOAT = 3'd4,
    S_TURN  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic                read_q, read_d;
  logic [NUM_CS-1:0]   cs_q, cs_d;
  logic                last_q, last_d;
  logic [CSLE_W-1:0]   csle_q, csle_d;
  logic [WS_W-1:0]     ws_q, ws_d;
  logic [CSTE_W-1:0]   cste_q, cste_d;
  logic [WS_W-1:0]     oete_q, oete_d;
  logic [TURN_W-1:0]   turn_q, turn_d;
  logic [CSLE_W-1:0]   le_cnt_q, le_cnt_d;
  logic [WS_W-1:0]     ws_cnt_q, ws_cnt_d;
  logic [CSTE_W-1:0]   cste_cnt_q, cste_cnt_d;
  logic [TURN_W-1:0]   turn_cnt_q, turn_cnt_d;

  logic end_cycle;
  logic accept;
  logic change;
  logic unused_last;

  // last_q is held for the MAC only; no exported output depends on it.
  assign unused_last = last_q;

  assign end_cycle = ((state_q == S_RW) && (ws_cnt_q == '0) && (cste_q == '0)) ||
                     ((state_q == S_FLOAT) && (cste_cnt_q == '0));
  assign acc_ready = (state_q == S_IDLE) || end_cycle;
  assign accept    = acc_valid && acc_ready;
  assign change    = (acc_read != read_q) || (acc_cs != cs_q);
  assign smc_idle  = (state_d == S_IDLE);

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q    <= S_IDLE;
      read_q     <= 1'b0;
      cs_q       <= '0;
      last_q     <= 1'b0;
      csle_q     <= '0;
      ws_q       <= '0;
      cste_q     <= '0;
      oete_q     <= '0;
      turn_q     <= '0;
      le_cnt_q   <= '0;
      ws_cnt_q   <= '0;
      cste_cnt_q <= '0;
      turn_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      read_q     <= read_d;
      cs_q       <= cs_d;
      last_q     <= last_d;
      csle_q     <= csle_d;
      ws_q       <= ws_d;
      cste_q     <= cste_d;
      oete_q     <= oete_d;
      turn_q     <= turn_d;
      le_cnt_q   <= le_cnt_d;
      ws_cnt_q   <= ws_cnt_d;
      cste_cnt_q <= cste_cnt_d;
      turn_cnt_q <= turn_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    read_d     = read_q;
    cs_d       = cs_q;
    last_d     = last_q;
    csle_d     = csle_q;
    ws_d       = ws_q;
    cste_d     = cste_q;
    oete_d     = oete_q;
    turn_d     = turn_q;
    le_cnt_d   = le_cnt_q;
    ws_cnt_d   = ws_cnt_q;
    cste_cnt_d = cste_cnt_q;
    turn_cnt_d = turn_cnt_q;

    if (accept) begin
      read_d = acc_read;
      cs_d   = acc_cs;
      last_d = acc_last;
      csle_d = t_csle;
      ws_d   = t_ws;
      cste_d = t_cste;
      oete_d = t_oete;
      turn_d = t_turn;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_STORE;
      end
      S_STORE: begin
        if (csle_q != '0) begin
          state_d  = S_LE;
          le_cnt_d = csle_q - CSLE_W'(1);
        end else begin
          state_d  = S_RW;
          ws_cnt_d = ws_q;
        end
      end
      S_LE: begin
        if (le_cnt_q == '0) begin
          state_d  = S_RW;
          ws_cnt_d = ws_q;
        end else begin
          le_cnt_d = le_cnt_q - CSLE_W'(1);
        end
      end
      S_RW: begin
        if (ws_cnt_q != '0) begin
          ws_cnt_d = ws_cnt_q - WS_W'(1);
        end else if (cste_q != '0) begin
          state_d    = S_FLOAT;
          cste_cnt_d = cste_q - CSTE_W'(1);
        end
      end
      S_FLOAT: begin
        if (cste_cnt_q != '0) cste_cnt_d = cste_cnt_q - CSTE_W'(1);
      end
      S_TURN: begin
        if (turn_cnt_q == '0) state_d = S_STORE;
        else                  turn_cnt_d = turn_cnt_q - TURN_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    // Turnaround length comes from the access just finishing, not the new one.
    if (end_cycle) begin
      if (!accept) begin
        state_d = S_IDLE;
      end else if (!change) begin
        state_d  = S_RW;
        ws_cnt_d = t_ws;
      end else if (turn_q != '0) begin
        state_d    = S_TURN;
        turn_cnt_d = turn_q - TURN_W'(1);
      end else begin
        state_d = S_STORE;
      end
    end
  end

  always_comb begin
    cs_n       = '1;
    oe_n       = 1'b1;
    we_n       = 1'b1;
    latch_data = 1'b0;
    smc_done   = end_cycle;
    smc_state  = state_q;
    if ((state_q == S_STORE) || (state_q == S_LE) ||
        (state_q == S_RW) || (state_q == S_FLOAT)) begin
      cs_n = ~cs_q;
    end
    if (state_q == S_RW) begin
      oe_n       = ~read_q;
      we_n       = ~(~read_q && (ws_cnt_q != '0));
      latch_data = read_q && ((ws_cnt_q == oete_q) ||
                              ((oete_q > ws_q) && (ws_cnt_q == '0)));
    end
  end

endmodule

// File: tb/tb_smc_timing_fsm.sv
// Self-checking bench for smc_timing_fsm: per-cycle expected outputs are queued
// when each request is driven and compared on the falling clock edge.
module tb_smc_timing_fsm;

  logic       sys_clk;
  logic       sys_reset;
  logic       acc_valid;
  logic       acc_ready;
  logic       acc_read;
  logic [3:0] acc_cs;
  logic       acc_last;
  logic [1:0] t_csle;
  logic [7:0] t_ws;
  logic [1:0] t_cste;
  logic [7:0] t_oete;
  logic [1:0] t_turn;
  logic [3:0] cs_n;
  logic       oe_n;
  logic       we_n;
  logic       latch_data;
  logic       smc_done;
  logic       smc_idle;
  logic [2:0] smc_state;

  smc_timing_fsm #(
    .NUM_CS(4),
    .WS_W  (8),
    .CSLE_W(2),
    .CSTE_W(2),
    .TURN_W(2)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_reset (sys_reset),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .acc_read  (acc_read),
    .acc_cs    (acc_cs),
    .acc_last  (acc_last),
    .t_csle    (t_csle),
    .t_ws      (t_ws),
    .t_cste    (t_cste),
    .t_oete    (t_oete),
    .t_turn    (t_turn),
    .cs_n      (cs_n),
    .oe_n      (oe_n),
    .we_n      (we_n),
    .latch_data(latch_data),
    .smc_done  (smc_done),
    .smc_idle  (smc_idle),
    .smc_state (smc_state)
  );

  typedef struct {
    logic       read;
    logic [3:0] cs;
    logic [1:0] csle;
    logic [7:0] ws;
    logic [1:0] cste;
    logic [7:0] oete;
    logic [1:0] turn;
  } req_t;

  typedef struct {
    req_t r;
    int   done_at;
    int   latch_at;
  } vec_t;

  typedef struct {
    logic [2:0] st;
    logic [3:0] cs_n;
    logic       oe_n;
    logic       we_n;
    logic       latch;
    logic       done;
    logic       ready;
    logic       idle;
  } exp_t;

  exp_t exp_q[$];
  exp_t ce;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cyc++;

  always @(posedge sys_clk)
    if (!sys_reset && acc_valid && acc_ready)
      assert ($onehot(acc_cs)) else $error("acc_cs must be one-hot");

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endfunction

  function automatic exp_t mk(logic [2:0] st, logic [3:0] csn, logic oe, logic we,
                              logic la, logic dn, logic rd, logic id);
    exp_t e;
    e.st = st; e.cs_n = csn; e.oe_n = oe; e.we_n = we;
    e.latch = la; e.done = dn; e.ready = rd; e.idle = id;
    return e;
  endfunction

  always @(negedge sys_clk) begin
    if (!sys_reset && exp_q.size() != 0) begin
      ce = exp_q.pop_front();
      chk("state", smc_state, ce.st);
      chk("cs_n",  cs_n,      ce.cs_n);
      chk("oe_n",  oe_n,      ce.oe_n);
      chk("we_n",  we_n,      ce.we_n);
      chk("latch", latch_data, ce.latch);
      chk("done",  smc_done,  ce.done);
      chk("ready", acc_ready, ce.ready);
      chk("idle",  smc_idle,  ce.idle);
    end
  end

  // Expected trace of one access, phase by phase; from_rw enters RW directly
  // (back-to-back), acc_end means another request is taken on the end cycle.
  task automatic push_access(input req_t r, input bit from_rw, input bit acc_end);
    int li;
    bit last;
    bit fin;
    if (!from_rw) begin
      exp_q.push_back(mk(3'd1, ~r.cs, 1, 1, 0, 0, 0, 0));
      for (int i = 0; i < int'(r.csle); i++)
        exp_q.push_back(mk(3'd2, ~r.cs, 1, 1, 0, 0, 0, 0));
    end
    li = (r.oete > r.ws) ? int'(r.ws) : int'(r.ws) - int'(r.oete);
    for (int i = 0; i <= int'(r.ws); i++) begin
      last = (i == int'(r.ws));
      fin  = last && (r.cste == 2'd0);
      exp_q.push_back(mk(3'd3, ~r.cs, ~r.read, r.read | last, r.read && (i == li),
                         fin, fin, fin && !acc_end));
    end
    for (int j = 1; j <= int'(r.cste); j++) begin
      fin = (j == int'(r.cste));
      exp_q.push_back(mk(3'd4, ~r.cs, 1, 1, 0, fin, fin, fin && !acc_end));
    end
    if (!acc_end) exp_q.push_back(mk(3'd0, 4'hF, 1, 1, 0, 0, 1, 1));
  endtask

  task automatic drive(input req_t r);
    acc_read = r.read; acc_cs = r.cs; t_csle = r.csle; t_ws = r.ws;
    t_cste = r.cste; t_oete = r.oete; t_turn = r.turn; acc_last = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(negedge sys_clk);
    #1;
    chk("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_pair(input req_t a, input req_t b);
    bit got;
    @(posedge sys_clk); #1;
    drive(a);
    acc_valid = 1'b1;
    exp_q.push_back(mk(3'd0, 4'hF, 1, 1, 0, 0, 1, 0));
    push_access(a, 0, 1);
    if (a.read == b.read && a.cs == b.cs) begin
      push_access(b, 1, 0);
    end else begin
      for (int t = 0; t < int'(a.turn); t++)
        exp_q.push_back(mk(3'd5, 4'hF, 1, 1, 0, 0, 0, 0));
      push_access(b, 0, 0);
    end
    @(posedge sys_clk); #1;
    drive(b);
    got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge sys_clk);
      if (acc_ready) got = 1'b1;
    end
    chk("pair_accept", got, 1);
    @(posedge sys_clk); #1;
    acc_valid = 1'b0;
    drain();
  endtask

  vec_t vec[6];
  req_t ra, rb;
  int   done_at, latch_at, nl;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{'{1'b1, 4'b0010, 2'd0, 8'd2, 2'd0, 8'd1, 2'd0}, 4, 3};
    vec[1] = '{'{1'b0, 4'b0001, 2'd2, 8'd3, 2'd2, 8'd0, 2'd0}, 9, -1};
    vec[2] = '{'{1'b1, 4'b0100, 2'd1, 8'd2, 2'd1, 8'd5, 2'd0}, 6, 5};
    vec[3] = '{'{1'b1, 4'b1000, 2'd0, 8'd0, 2'd0, 8'd0, 2'd0}, 2, 2};
    vec[4] = '{'{1'b0, 4'b0010, 2'd3, 8'd0, 2'd0, 8'd0, 2'd0}, 5, -1};
    vec[5] = '{'{1'b1, 4'b0001, 2'd0, 8'd3, 2'd3, 8'd3, 2'd0}, 8, 2};

    sys_reset = 1'b0; acc_valid = 1'b0; acc_read = 1'b0; acc_cs = '0; acc_last = 1'b0;
    t_csle = '0; t_ws = '0; t_cste = '0; t_oete = '0; t_turn = '0;
    #1 sys_reset = 1'b1;
    #2;
    chk("rst_state", smc_state, 0);
    chk("rst_cs_n",  cs_n, 4'hF);
    chk("rst_oe_n",  oe_n, 1);
    chk("rst_we_n",  we_n, 1);
    chk("rst_latch", latch_data, 0);
    chk("rst_done",  smc_done, 0);
    chk("rst_idle",  smc_idle, 1);
    chk("rst_ready", acc_ready, 1);
    @(posedge sys_clk); #1 sys_reset = 1'b0;

    for (int k = 0; k < 6; k++) begin
      @(posedge sys_clk); #1;
      drive(vec[k].r);
      acc_valid = 1'b1;
      exp_q.push_back(mk(3'd0, 4'hF, 1, 1, 0, 0, 1, 0));
      push_access(vec[k].r, 0, 0);
      done_at = -1; latch_at = -1; nl = 0;
      for (int c = 0; c < 40 && done_at < 0; c++) begin
        @(negedge sys_clk);
        if (smc_done) done_at = c;
        if (latch_data) begin nl++; latch_at = c; end
        @(posedge sys_clk); #1;
        acc_valid = 1'b0;
      end
      chk("done_cycle",  done_at,  vec[k].done_at);
      chk("latch_cycle", latch_at, vec[k].latch_at);
      chk("latch_count", nl, vec[k].r.read ? 1 : 0);
      drain();
    end

    ra = '{1'b1, 4'b0010, 2'd0, 8'd1, 2'd0, 8'd0, 2'd0};
    rb = '{1'b1, 4'b0010, 2'd0, 8'd0, 2'd0, 8'd0, 2'd0};
    run_pair(ra, rb);
    ra = '{1'b0, 4'b0001, 2'd0, 8'd2, 2'd1, 8'd0, 2'd1};
    rb = '{1'b0, 4'b0001, 2'd2, 8'd1, 2'd0, 8'd0, 2'd0};
    run_pair(ra, rb);
    ra = '{1'b1, 4'b0010, 2'd0, 8'd1, 2'd0, 8'd1, 2'd2};
    rb = '{1'b0, 4'b0100, 2'd0, 8'd2, 2'd0, 8'd0, 2'd0};
    run_pair(ra, rb);
    ra = '{1'b1, 4'b0010, 2'd0, 8'd1, 2'd0, 8'd1, 2'd0};
    rb = '{1'b0, 4'b0100, 2'd1, 8'd2, 2'd1, 8'd0, 2'd0};
    run_pair(ra, rb);
    ra = '{1'b0, 4'b1000, 2'd1, 8'd1, 2'd0, 8'd0, 2'd3};
    rb = '{1'b0, 4'b0001, 2'd0, 8'd1, 2'd0, 8'd0, 2'd0};
    run_pair(ra, rb);

    // Reset in the middle of a read's RW phase.
    @(posedge sys_clk); #1;
    drive('{1'b1, 4'b0010, 2'd0, 8'd5, 2'd0, 8'd1, 2'd0});
    acc_valid = 1'b1;
    @(posedge sys_clk); #1 acc_valid = 1'b0;
    @(posedge sys_clk); #1;
    chk("pre_rst_state", smc_state, 3);
    chk("pre_rst_oe_n",  oe_n, 0);
    #2 sys_reset = 1'b1;
    #1;
    chk("mid_rst_state", smc_state, 0);
    chk("mid_rst_cs_n",  cs_n, 4'hF);
    chk("mid_rst_oe_n",  oe_n, 1);
    chk("mid_rst_ready", acc_ready, 1);
    chk("mid_rst_latch", latch_data, 0);
    @(posedge sys_clk); #1 sys_reset = 1'b0;

    run_pair('{1'b1, 4'b0010, 2'd0, 8'd0, 2'd0, 8'd0, 2'd1},
             '{1'b1, 4'b0001, 2'd0, 8'd1, 2'd0, 8'd0, 2'd0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
